// File: rtl/i2cmaster_pkg.sv
// Shared constants for the byte-level I2C master: FSM states, quarter-bit
// phase numbers and the R/nW bit position inside the address byte.
package i2cmaster_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_RESTART,
        ST_ADDR,
        ST_ADDRACK,
        ST_WDATA,
        ST_RDATA,
        ST_DATAACK,
        ST_HOLD,
        ST_STOP
    } state_t;

    // Quarter-bit phases: SDA changes in LOW_SETUP, SCL is high in HIGH_A and
    // SAMPLE (SDA sampled on entry to SAMPLE), SCL falls again in LOW_HOLD.
    localparam logic [1:0] PH_LOW_SETUP = 2'd0;
    localparam logic [1:0] PH_HIGH_A    = 2'd1;
    localparam logic [1:0] PH_SAMPLE    = 2'd2;
    localparam logic [1:0] PH_LOW_HOLD  = 2'd3;

    localparam int RNW_BIT = 0;

    // The quarter-tick counter is stopped while the master is parked.
    function automatic logic is_parked(input state_t s);
        return (s == ST_IDLE) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/i2cmaster_i2ctick.sv
// Quarter-SCL-period divider: strobes tick once every CLKDIV enabled,
// unfrozen cycles; pre_tick marks the cycle just before a tick.
module i2ctick #(
    parameter int CLKDIV = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic freeze,
    output logic tick,
    output logic pre_tick
);

    localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (!en) begin
            count_reg <= '0;
        end else if (!freeze) begin
            count_reg <= (count_reg == CW'(CLKDIV - 1)) ? '0 : count_reg + 1'b1;
        end
    end

    assign tick     = en && !freeze && (count_reg == CW'(CLKDIV - 1));
    assign pre_tick = en && !freeze && (count_reg == CW'(CLKDIV - 2));

endmodule

// File: rtl/i2cmaster.sv
// Byte-level I2C master: one data byte per arbiter beat, with START/repeated
// START and address phase as needed. Define I2C_STRETCH_EN for clock stretching.
module i2cmaster
    import i2cmaster_pkg::*;
#(
    parameter int CLKDIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] addr,
    input  logic [7:0] wrdata,
    input  logic       req,
    input  logic       last,
    output logic [7:0] rddata,
    output logic       ack,
    output logic       err,
    output logic       scl_o,
    output logic       sda_o,
    input  logic       scl_i,
    input  logic       sda_i
);

    state_t     state_reg;
    logic [1:0] phase_reg;
    logic [2:0] bitcnt_reg;
    logic [7:0] shreg_reg;
    logic [7:0] curaddr_reg;
    logic       last_reg;
    logic       nack_reg;
    logic       scl_reg;
    logic       sda_reg;
    logic       ack_reg;
    logic       err_reg;
    logic [7:0] rddata_reg;

    logic tick;
    logic pre_tick;
    logic freeze;
    logic tick_en;
    logic rd_mode;

    assign tick_en = !is_parked(state_reg);
    assign rd_mode = curaddr_reg[RNW_BIT];

`ifdef I2C_STRETCH_EN
    // A slave holding SCL low while we release it stalls the high phase.
    assign freeze = scl_reg && !scl_i &&
                    ((phase_reg == PH_HIGH_A) || (phase_reg == PH_SAMPLE));
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign freeze     = 1'b0;
`endif

    i2ctick #(
        .CLKDIV(CLKDIV)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .en      (tick_en),
        .freeze  (freeze),
        .tick    (tick),
        .pre_tick(pre_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            phase_reg   <= PH_LOW_SETUP;
            bitcnt_reg  <= 3'd0;
            shreg_reg   <= 8'h00;
            curaddr_reg <= 8'h00;
            last_reg    <= 1'b0;
            nack_reg    <= 1'b0;
            scl_reg     <= 1'b1;
            sda_reg     <= 1'b1;
            ack_reg     <= 1'b0;
            err_reg     <= 1'b0;
            rddata_reg  <= 8'h00;
        end else begin
            ack_reg <= 1'b0;
            err_reg <= 1'b0;

            // ack is raised one cycle ahead so it covers the last clk of the ack bit.
            if (pre_tick && phase_reg == PH_LOW_HOLD) begin
                if (state_reg == ST_ADDRACK && nack_reg) begin
                    ack_reg <= 1'b1;
                    err_reg <= 1'b1;
                end
                if (state_reg == ST_DATAACK) begin
                    ack_reg <= 1'b1;
                    err_reg <= nack_reg;
                    if (rd_mode) begin
                        rddata_reg <= shreg_reg;
                    end
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    scl_reg <= 1'b1;
                    sda_reg <= 1'b1;
                    if (req) begin
                        state_reg   <= ST_START;
                        phase_reg   <= PH_LOW_SETUP;
                        curaddr_reg <= addr;
                        shreg_reg   <= addr;
                        last_reg    <= last;
                        sda_reg     <= 1'b0;
                    end
                end

                ST_HOLD: begin
                    if (req) begin
                        last_reg   <= last;
                        phase_reg  <= PH_LOW_SETUP;
                        bitcnt_reg <= 3'd7;
                        if (addr != curaddr_reg) begin
                            state_reg   <= ST_RESTART;
                            curaddr_reg <= addr;
                            shreg_reg   <= addr;
                            sda_reg     <= 1'b1;
                        end else if (addr[RNW_BIT]) begin
                            state_reg <= ST_RDATA;
                            sda_reg   <= 1'b1;
                        end else begin
                            state_reg <= ST_WDATA;
                            shreg_reg <= wrdata;
                            sda_reg   <= wrdata[7];
                        end
                    end
                end

                default: begin
                    if (tick) begin
                        phase_reg <= phase_reg + 2'd1;
                        case (state_reg)
                            ST_START: begin
                                if (phase_reg == PH_LOW_SETUP) begin
                                    scl_reg <= 1'b0;
                                end else begin
                                    state_reg  <= ST_ADDR;
                                    phase_reg  <= PH_LOW_SETUP;
                                    bitcnt_reg <= 3'd7;
                                    sda_reg    <= shreg_reg[7];
                                end
                            end

                            ST_RESTART: begin
                                if (phase_reg == PH_LOW_SETUP) begin
                                    scl_reg <= 1'b1;
                                end else if (phase_reg == PH_SAMPLE) begin
                                    state_reg <= ST_START;
                                    phase_reg <= PH_LOW_SETUP;
                                    sda_reg   <= 1'b0;
                                end
                            end

                            ST_STOP: begin
                                if (phase_reg == PH_LOW_SETUP) begin
                                    scl_reg <= 1'b1;
                                end else if (phase_reg == PH_HIGH_A) begin
                                    sda_reg <= 1'b1;
                                end else begin
                                    state_reg <= ST_IDLE;
                                    phase_reg <= PH_LOW_SETUP;
                                end
                            end

                            ST_ADDR, ST_WDATA, ST_RDATA: begin
                                case (phase_reg)
                                    PH_LOW_SETUP: scl_reg <= 1'b1;
                                    PH_HIGH_A: begin
                                        if (state_reg == ST_RDATA) begin
                                            shreg_reg <= {shreg_reg[6:0], sda_i};
                                        end
                                    end
                                    PH_SAMPLE: scl_reg <= 1'b0;
                                    default: begin
                                        if (bitcnt_reg != 3'd0) begin
                                            bitcnt_reg <= bitcnt_reg - 3'd1;
                                            if (state_reg == ST_RDATA) begin
                                                sda_reg <= 1'b1;
                                            end else begin
                                                shreg_reg <= {shreg_reg[6:0], 1'b0};
                                                sda_reg   <= shreg_reg[6];
                                            end
                                        end else begin
                                            state_reg <= (state_reg == ST_ADDR) ? ST_ADDRACK : ST_DATAACK;
                                            // When reading, the master answers ACK unless this is the last byte.
                                            sda_reg   <= (state_reg == ST_RDATA) ? last_reg : 1'b1;
                                        end
                                    end
                                endcase
                            end

                            ST_ADDRACK, ST_DATAACK: begin
                                case (phase_reg)
                                    PH_LOW_SETUP: scl_reg <= 1'b1;
                                    PH_HIGH_A: begin
                                        nack_reg <= (state_reg == ST_DATAACK && rd_mode) ? 1'b0 : sda_i;
                                    end
                                    PH_SAMPLE: scl_reg <= 1'b0;
                                    default: begin
                                        phase_reg <= PH_LOW_SETUP;
                                        if (state_reg == ST_ADDRACK) begin
                                            bitcnt_reg <= 3'd7;
                                            if (nack_reg) begin
                                                state_reg <= ST_STOP;
                                                sda_reg   <= 1'b0;
                                            end else if (rd_mode) begin
                                                state_reg <= ST_RDATA;
                                                sda_reg   <= 1'b1;
                                            end else begin
                                                state_reg <= ST_WDATA;
                                                shreg_reg <= wrdata;
                                                sda_reg   <= wrdata[7];
                                            end
                                        end else if (nack_reg || last_reg) begin
                                            state_reg <= ST_STOP;
                                            sda_reg   <= 1'b0;
                                        end else begin
                                            state_reg <= ST_HOLD;
                                        end
                                    end
                                endcase
                            end

                            default: begin
                                state_reg <= ST_IDLE;
                                phase_reg <= PH_LOW_SETUP;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign scl_o  = scl_reg;
    assign sda_o  = sda_reg;
    assign ack    = ack_reg;
    assign err    = err_reg;
    assign rddata = rddata_reg;

endmodule

// File: tb/tb_i2cmaster.sv
// Directed bench for i2cmaster with an open-drain bus and a behavioural slave
// that logs START/STOP, bytes and acknowledge bits seen on the wires.
module tb_i2cmaster;

    localparam int CLKDIV  = 4;
    localparam int EV_START = 1000;
    localparam int EV_STOP  = 1001;
    localparam int EV_ACK   = 2000;
    localparam int EV_NACK  = 2001;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wrdata = 8'h00;
    logic       req = 1'b0;
    logic       last = 1'b0;
    logic [7:0] rddata;
    logic       ack;
    logic       err;
    logic       scl_o;
    logic       sda_o;
    logic       scl_i;
    logic       sda_i;

    logic slv_sda = 1'b1;
    logic slv_scl = 1'b1;
    logic scl;
    logic sda;
    assign scl   = scl_o & slv_scl;
    assign sda   = sda_o & slv_sda;
    assign scl_i = scl;
    assign sda_i = sda;

    int checks = 0;
    int errors = 0;

    // Slave configuration (written by the tests only)
    logic [6:0] slv_addr_a  = 7'h72;
    logic [6:0] slv_addr_b  = 7'h4F;
    logic [7:0] slv_rdbyte  = 8'h3C;
    int         nack_at     = -1;

    // Bus monitor / slave state (written by the monitor only)
    int         ev_log[256];
    int         ev_cnt = 0;
    int         bc = 0;
    int         byte_no = 0;
    logic [7:0] mon_sh = 8'h00;
    logic       addressed = 1'b0;
    logic       rdmode = 1'b0;
    logic       last_ackbit = 1'b1;

    always #5 clk = ~clk;

    i2cmaster #(.CLKDIV(CLKDIV)) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .wrdata(wrdata),
        .req   (req),
        .last  (last),
        .rddata(rddata),
        .ack   (ack),
        .err   (err),
        .scl_o (scl_o),
        .sda_o (sda_o),
        .scl_i (scl_i),
        .sda_i (sda_i)
    );

    always @(negedge sda) begin
        if (scl === 1'b1) begin
            if (ev_cnt < 256) ev_log[ev_cnt] = EV_START;
            ev_cnt++;
            bc = 0; byte_no = 0; rdmode = 1'b0; addressed = 1'b0; slv_sda = 1'b1;
        end
    end

    always @(posedge sda) begin
        if (scl === 1'b1) begin
            if (ev_cnt < 256) ev_log[ev_cnt] = EV_STOP;
            ev_cnt++;
            bc = 0; byte_no = 0; rdmode = 1'b0; addressed = 1'b0; slv_sda = 1'b1;
        end
    end

    always @(posedge scl) begin
        if (bc < 8) begin
            mon_sh = {mon_sh[6:0], sda};
            bc++;
            if (bc == 8) begin
                if (ev_cnt < 256) ev_log[ev_cnt] = int'(mon_sh);
                ev_cnt++;
            end
        end else begin
            last_ackbit = sda;
            if (ev_cnt < 256) ev_log[ev_cnt] = (sda === 1'b0) ? EV_ACK : EV_NACK;
            ev_cnt++;
            bc = 0;
            byte_no++;
        end
    end

    always @(negedge scl) begin
        if (bc == 8) begin
            if (byte_no == 0) begin
                addressed = (mon_sh[7:1] == slv_addr_a) || (mon_sh[7:1] == slv_addr_b);
                rdmode    = mon_sh[0];
                slv_sda   = addressed ? 1'b0 : 1'b1;
            end else if (rdmode) begin
                slv_sda = 1'b1;
            end else begin
                slv_sda = (addressed && byte_no != nack_at) ? 1'b0 : 1'b1;
            end
        end else if (rdmode && addressed && byte_no >= 1 && last_ackbit == 1'b0) begin
            slv_sda = slv_rdbyte[3'(7 - bc)];
        end else begin
            slv_sda = 1'b1;
        end
    end

    task automatic start_beat(input logic [7:0] a, input logic [7:0] w, input logic l);
        @(negedge clk);
        addr = a; wrdata = w; last = l; req = 1'b1;
    endtask

    // Waits (bounded) for the ack pulse, drops req in the ack cycle and reports
    // what was seen, including the bus event count at the ack and the ack level
    // one cycle later.
    task automatic wait_ack(output logic got, output logic e, output logic [7:0] rd,
                            output logic stray, output logic after, output int ev_at_ack);
        got = 1'b0; e = 1'b0; rd = 8'h00; stray = 1'b0; after = 1'b0; ev_at_ack = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                got = 1'b1; e = err; rd = rddata; ev_at_ack = ev_cnt;
                req = 1'b0;
                break;
            end
            if (err !== 1'b0) stray = 1'b1;
        end
        req = 1'b0;
        @(negedge clk);
        after = ack;
        $display("beat addr=%02h wrdata=%02h last=%0b ack=%0b err=%0b rddata=%02h",
                 addr, wrdata, last, got, e, rd);
    endtask

    task automatic settle();
        repeat (40) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (scl_o !== 1'b1) begin errors++; $display("FAIL reset_scl: got %b expected 1", scl_o); end
        checks++; if (sda_o !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b expected 1", sda_o); end
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (rddata !== 8'h00) begin errors++; $display("FAIL reset_rddata: got %02h expected 00", rddata); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_write();
        int exp_ev[8] = '{EV_START, 'hE4, EV_ACK, 'h10, EV_ACK, 'hA5, EV_ACK, EV_STOP};
        int base;
        logic got, e, stray, after;
        logic [7:0] rd;
        int ev_ack;
        base = ev_cnt;
        start_beat(8'hE4, 8'h10, 1'b0);
        wait_ack(got, e, rd, stray, after, ev_ack);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL write1_ack: got %b expected 1", got); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL write1_err: got %b expected 0", e); end
        checks++; if (after !== 1'b0) begin errors++; $display("FAIL write1_ack_width: ack after pulse %b expected 0", after); end
        checks++; if (stray !== 1'b0) begin errors++; $display("FAIL write1_err_idle: err without ack %b expected 0", stray); end
        start_beat(8'hE4, 8'hA5, 1'b1);
        wait_ack(got, e, rd, stray, after, ev_ack);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL write2_ack: got %b expected 1", got); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL write2_err: got %b expected 0", e); end
        checks++; if (ev_ack - base !== 7) begin errors++; $display("FAIL write2_stop_after_ack: events at ack %0d expected 7", ev_ack - base); end
        settle();
        checks++; if (ev_cnt - base !== 8) begin errors++; $display("FAIL write_event_count: got %0d expected 8", ev_cnt - base); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (ev_log[base + i] !== exp_ev[i]) begin
                errors++; $display("FAIL write_event[%0d]: got %0d expected %0d", i, ev_log[base + i], exp_ev[i]);
            end
        end
        checks++; if ({scl_o, sda_o} !== 2'b11) begin errors++; $display("FAIL write_idle_bus: got %b expected 11", {scl_o, sda_o}); end
    endtask

    task automatic test_read();
        int exp_ev[11] = '{EV_START, 'h9E, EV_ACK, 'h00, EV_ACK,
                           EV_START, 'h9F, EV_ACK, 'h3C, EV_NACK, EV_STOP};
        int base;
        logic got, e, stray, after;
        logic [7:0] rd;
        int ev_ack;
        base = ev_cnt;
        start_beat(8'h9E, 8'h00, 1'b0);
        wait_ack(got, e, rd, stray, after, ev_ack);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL read_setup_ack: got %b expected 1", got); end
        start_beat(8'h9F, 8'h00, 1'b1);
        wait_ack(got, e, rd, stray, after, ev_ack);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL read_ack: got %b expected 1", got); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL read_err: got %b expected 0", e); end
        checks++; if (rd !== 8'h3C) begin errors++; $display("FAIL read_rddata: got %02h expected 3c", rd); end
        settle();
        checks++; if (rddata !== 8'h3C) begin errors++; $display("FAIL read_rddata_held: got %02h expected 3c", rddata); end
        checks++; if (ev_cnt - base !== 11) begin errors++; $display("FAIL read_event_count: got %0d expected 11", ev_cnt - base); end
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (ev_log[base + i] !== exp_ev[i]) begin
                errors++; $display("FAIL read_event[%0d]: got %0d expected %0d", i, ev_log[base + i], exp_ev[i]);
            end
        end
    endtask

    task automatic test_addr_nack();
        int exp_ev[4] = '{EV_START, 'h40, EV_NACK, EV_STOP};
        int base;
        logic got, e, stray, after;
        logic [7:0] rd;
        int ev_ack;
        base = ev_cnt;
        start_beat(8'h40, 8'h55, 1'b0);
        wait_ack(got, e, rd, stray, after, ev_ack);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL addr_nack_ack: got %b expected 1", got); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL addr_nack_err: got %b expected 1", e); end
        checks++; if (after !== 1'b0) begin errors++; $display("FAIL addr_nack_ack_width: ack after pulse %b expected 0", after); end
        settle();
        checks++; if (ev_cnt - base !== 4) begin errors++; $display("FAIL addr_nack_event_count: got %0d expected 4", ev_cnt - base); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ev_log[base + i] !== exp_ev[i]) begin
                errors++; $display("FAIL addr_nack_event[%0d]: got %0d expected %0d", i, ev_log[base + i], exp_ev[i]);
            end
        end
        checks++; if ({scl_o, sda_o} !== 2'b11) begin errors++; $display("FAIL addr_nack_idle_bus: got %b expected 11", {scl_o, sda_o}); end
    endtask

    task automatic test_data_nack();
        int exp_ev[8] = '{EV_START, 'hE4, EV_ACK, 'h11, EV_ACK, 'h22, EV_NACK, EV_STOP};
        int base;
        logic got, e, stray, after;
        logic [7:0] rd;
        int ev_ack;
        base = ev_cnt;
        nack_at = 2;
        start_beat(8'hE4, 8'h11, 1'b0);
        wait_ack(got, e, rd, stray, after, ev_ack);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL data_nack_first_err: got %b expected 0", e); end
        start_beat(8'hE4, 8'h22, 1'b0);
        wait_ack(got, e, rd, stray, after, ev_ack);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL data_nack_ack: got %b expected 1", got); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL data_nack_err: got %b expected 1", e); end
        settle();
        nack_at = -1;
        checks++; if (ev_cnt - base !== 8) begin errors++; $display("FAIL data_nack_event_count: got %0d expected 8", ev_cnt - base); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (ev_log[base + i] !== exp_ev[i]) begin
                errors++; $display("FAIL data_nack_event[%0d]: got %0d expected %0d", i, ev_log[base + i], exp_ev[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int exp_ev[6] = '{EV_START, 'hE4, EV_ACK, 'h77, EV_ACK, EV_STOP};
        int base;
        logic got, e, stray, after;
        logic [7:0] rd;
        int ev_ack;
        start_beat(8'hE4, 8'h77, 1'b1);
        // 8 cycles of START plus three 16-cycle bits lands in the high phase of bit 3.
        repeat (62) @(negedge clk);
        checks++; if (scl_o !== 1'b1 || ev_cnt == 0) begin errors++; $display("FAIL reset_mid_in_bit3: scl_o %b expected 1", scl_o); end
        rst = 1'b1;
        #1;
        checks++; if (scl_o !== 1'b1) begin errors++; $display("FAIL reset_mid_scl: got %b expected 1", scl_o); end
        checks++; if (sda_o !== 1'b1) begin errors++; $display("FAIL reset_mid_sda: got %b expected 1", sda_o); end
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_mid_ack: got %b expected 0", ack); end
        req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        base = ev_cnt;
        start_beat(8'hE4, 8'h77, 1'b1);
        wait_ack(got, e, rd, stray, after, ev_ack);
        checks++; if (got !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL reset_mid_next_beat: ack %b err %b expected ack 1 err 0", got, e); end
        settle();
        checks++; if (ev_cnt - base !== 6) begin errors++; $display("FAIL reset_mid_event_count: got %0d expected 6", ev_cnt - base); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (ev_log[base + i] !== exp_ev[i]) begin
                errors++; $display("FAIL reset_mid_event[%0d]: got %0d expected %0d", i, ev_log[base + i], exp_ev[i]);
            end
        end
    endtask

`ifdef I2C_STRETCH_EN
    task automatic test_stretch();
        int base;
        int hi;
        logic seen;
        logic got, e, stray, after;
        logic [7:0] rd;
        int ev_ack;
        base = ev_cnt;
        hi = 0;
        seen = 1'b0;
        start_beat(8'hE4, 8'h5A, 1'b1);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bc == 5 && scl === 1'b0 && ev_cnt - base == 1) begin
                slv_scl = 1'b0;
                break;
            end
        end
        for (int i = 0; i < 500; i++) begin
            if (scl_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (seen) begin
            hi = 1;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (scl_o === 1'b1) hi++;
                if (i == 49) slv_scl = 1'b1;
            end
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (scl_o !== 1'b1) break;
                hi++;
            end
        end
        slv_scl = 1'b1;
        checks++; if (hi !== 2 * CLKDIV + 50) begin errors++; $display("FAIL stretch_high_len: got %0d expected %0d", hi, 2 * CLKDIV + 50); end
        wait_ack(got, e, rd, stray, after, ev_ack);
        checks++; if (got !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL stretch_ack: ack %b err %b expected ack 1 err 0", got, e); end
        checks++; if (ev_log[base + 1] !== 'hE4) begin errors++; $display("FAIL stretch_byte: got %0h expected e4", ev_log[base + 1]); end
        settle();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_data_nack();
        test_reset_mid();
`ifdef I2C_STRETCH_EN
        test_stretch();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
